serial_word_receiver: RTL
=========================

Name: serial_word_receiver

Overview:
- Serial-in/parallel-out receiving end for the team's shift-register serial links (24-bit and 80-bit words).
- Accepts a qualified serial bit stream MSB-first (bit WIDTH-1 first), framed by a start strobe.
- Assembles WIDTH bits into a word and presents it on a one-entry output holding register with a valid/ready handshake.
- Sits downstream of a parallel-load shift-register transmitter whose Ser_Out carries the MSB.

Parameters:
- WIDTH, 24, word length in bits. Must be at least 2; the bench also runs 80.
- CNT_W, $clog2(WIDTH+1), width of the bit counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- Ser_In  input  1  serial data bit.
- bit_valid  input  1  Ser_In is valid this cycle.
- start  input  1  frame sync; begins a new word.
- out_ready  input  1  consumer accepts Par_out this cycle.
- ovr_clr  input  1  clears the overrun flag.
- Par_out  output  WIDTH  received word from the holding register.
- out_valid  output  1  holding register is full.
- busy  output  1  frame reception in progress.
- bit_cnt  output  CNT_W  bits received in the current frame.
- overrun  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - The shift register, Par_out, bit_cnt, out_valid, overrun and busy all go to 0.
  - Any partial frame is discarded immediately.
- State machine, IDLE and RECV:
  - busy = 1 exactly when in RECV.
  - IDLE: bit_valid without start is ignored.
  - start=1 in any state: clear the shift register, set bit_cnt=0, go to RECV. A partial frame in RECV is aborted silently and does not set overrun.
  - start=1 and bit_valid=1 in the same cycle: that bit is the first bit of the new frame. Result: bit_cnt=1, shift register = {0…, Ser_In}.
  - RECV with bit_valid=1: shift register <= {shreg[WIDTH-2:0], Ser_In}; bit_cnt increments.
  - RECV with bit_valid=0: hold. Gaps of any length are allowed.
- Word completion (the edge that samples the WIDTH-th bit):
  - The full word is {shreg[WIDTH-2:0], Ser_In}.
  - State goes to IDLE and bit_cnt goes to 0.
  - Holding register empty, or being drained this same cycle (out_valid & out_ready): the word loads into Par_out and out_valid=1 from the next cycle. Latency is one edge after the last bit, with no bubble.
  - Holding register full and not draining: the new word is dropped, Par_out and out_valid are unchanged, and overrun is set to 1.
- Output handshake:
  - A transfer occurs on an edge where out_valid=1 and out_ready=1. After it, out_valid=0 unless a new word loads on the same edge.
  - Par_out is stable while out_valid=1 and out_ready=0.
  - Par_out keeps its last value after being drained; it is not cleared.
  - out_ready while out_valid=0 has no effect.
- Overrun flag:
  - Sticky until rst or ovr_clr.
  - If a set and ovr_clr happen in the same cycle, set wins: overrun=1.
- Arithmetic: bit_cnt is compared against WIDTH-1 at the bit_valid edge. There is no wrap; the counter never exceeds WIDTH-1 while in RECV.

Test Plan:
1. WIDTH=24, no backpressure: start with the first bit, then 0xA5A5A5 MSB-first on 24 consecutive bit_valid cycles, out_ready=1 -> out_valid pulses 1 cycle after the 24th bit edge, Par_out=24'hA5A5A5, busy low from the same edge, overrun=0.
2. Gapped stream plus backpressure:
   - Send 0x123456 with bit_valid toggling 1/0, out_ready=0 -> Par_out=24'h123456, held with out_valid=1.
   - Then send 0xFFFFFF -> overrun=1 and Par_out still 24'h123456.
   - Pulse ovr_clr -> overrun=0.
3. Completion coincident with drain: the first word is held, and out_ready=1 on exactly the edge the second word's last bit arrives -> out_valid stays 1 continuously and Par_out changes to the second word with no overrun.
4. Start mid-frame and reset mid-frame:
   - Send 10 bits, then assert start and send a full 0x00FF00 -> Par_out=24'h00FF00, no overrun, no spurious out_valid.
   - Assert rst asynchronously after 12 bits -> all outputs 0 immediately, and a later frame is received correctly.
5. WIDTH=80: send 80'h123456789ABCDEF01234 -> Par_out matches after the 80th bit edge; bit_cnt reads 79 just before that edge and 0 after it.

Source files
------------

// File: rtl/serial_word_receiver_if.sv
// Bundle of serial-link receive signals shared by the receiver and whoever
// drives it.
//   Ser_In, bit_valid : qualified serial bit stream, MSB first
//   start             : frame sync; the next word begins here
//   out_ready         : consumer accepts Par_out this cycle
//   ovr_clr           : clears the sticky overrun flag
//   Par_out/out_valid : one-entry holding register and its full flag
//   busy, bit_cnt     : frame-in-progress status and bit count
//   overrun           : a completed word was dropped
// The master modport is the stimulus/consumer side; the slave modport is
// the receiver itself.
interface serial_word_receiver_if #(
  parameter int WIDTH = 24,
  parameter int CNT_W = $clog2(WIDTH + 1)
) ();
  logic             Ser_In;
  logic             bit_valid;
  logic             start;
  logic             out_ready;
  logic             ovr_clr;
  logic [WIDTH-1:0] Par_out;
  logic             out_valid;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;

  modport master (
    output Ser_In, bit_valid, start, out_ready, ovr_clr,
    input  Par_out, out_valid, busy, bit_cnt, overrun
  );

  modport slave (
    input  Ser_In, bit_valid, start, out_ready, ovr_clr,
    output Par_out, out_valid, busy, bit_cnt, overrun
  );
endinterface

// File: rtl/serial_word_receiver.sv
// Serial-in / parallel-out receiver for the shift-register serial links.
// Bits arrive MSB first, qualified by bit_valid, and a frame begins on
// start. After WIDTH bits the word is offered on a one-entry holding
// register (Par_out/out_valid) with a valid/ready handshake; a word that
// completes while the holding register is full and not draining is
// dropped and flagged on the sticky overrun output.
// Ports: clk, rst (async, active high), bus (slave modport of
// serial_word_receiver_if carrying all data/handshake/status signals).
module serial_word_receiver #(
  parameter int WIDTH = 24,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_word_receiver_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t           state_q, state_d;
  // Only WIDTH-1 bits are ever held: the last bit goes straight into the word.
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] word_s;
  logic             drain_s;

  // Next-state, datapath and handshake logic.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    word_s  = {shreg_q, bus.Ser_In};
    drain_s = valid_q & bus.out_ready;

    if (drain_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (bus.ovr_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end

    if (bus.start) begin
      // A new frame discards any partial one without flagging it.
      state_d = RECV;
      shreg_d = '0;
      cnt_d   = '0;
      if (bus.bit_valid) begin
        shreg_d[0] = bus.Ser_In;
        cnt_d      = CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RECV: begin
          if (bus.bit_valid) begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_d = IDLE;
              cnt_d   = '0;
              shreg_d = '0;
              // Load when empty or when the held word leaves this same edge.
              if (!valid_q || drain_s) begin
                par_d   = word_s;
                valid_d = 1'b1;
              end else begin
                ovr_d = 1'b1;  // set overrides a simultaneous ovr_clr
              end
            end else begin
              shreg_d = word_s[WIDTH-2:0];
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = RECV;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          shreg_d = '0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      par_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.Par_out   = par_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state_q == RECV);
  assign bus.bit_cnt   = cnt_q;
  assign bus.overrun   = ovr_q;

endmodule
